if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch front end of the 5-stage MIPS pipeline, sitting directly upstream of the ID stage and control unit.
- Holds the PC/nPC register pair and drives the combinational instruction-memory address.
- Applies hazard-unit load enables and delayed-branch redirects from ID.
- Produces the IF/ID pipeline register (instruction, PC, PC+8 link value) plus fetch and stall performance counters.

Parameters:
RESET_PC, 0, PC value loaded on reset
RESET_NPC, 4, nPC value loaded on reset
IMEM_AW, 9, instruction-memory address width (byte address)
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  pipeline clock, rising-edge
reset  in  1  asynchronous, active-low reset
pc_le  in  1  PC load enable from hazard unit
npc_le  in  1  nPC load enable from hazard unit
if_id_le  in  1  IF/ID register load enable from hazard unit
id_ta_instr  in  1  ID holds a taken branch/jump; redirect requested
id_target_addr  in  32  branch/jump target address from ID
imem_instr  in  32  instruction returned by instruction memory
imem_addr  out  IMEM_AW  pc[IMEM_AW-1:0] to instruction memory
pc_out  out  32  current PC
npc_out  out  32  current nPC
if_id_instr  out  32  IF/ID instruction register
if_id_pc  out  32  PC of instruction in IF/ID
if_id_link  out  32  PC+8 of instruction in IF/ID (jal/bal link value)
misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0
fetch_count  out  CNT_W  instructions loaded into IF/ID, saturating
stall_count  out  CNT_W  cycles with pc_le==0 in RUN, saturating

Behaviour:
- Reset (reset==0, async):
  - pc=RESET_PC, npc=RESET_NPC.
  - if_id_instr/if_id_pc/if_id_link=0 (0 is NOP).
  - misalign_err=0, both counters=0, pending=0, state=BOOT.
- States: BOOT, RUN.
  - BOOT lasts exactly one rising edge after reset release.
  - On that edge: IF/ID loads NOP (0) regardless of if_id_le; pc/npc do not change; state->RUN.
- RUN sequential update, per rising edge:
  - pc: if pc_le, pc<=npc.
  - npc: if npc_le, npc<=redirect ? target : npc+4.
    - redirect = id_ta_instr | pending.
    - target = id_ta_instr ? id_target_addr : pending_ta.
    - Delay slot: the instruction at old nPC is always executed; it is never flushed.
  - IF/ID: if if_id_le, load if_id_instr<=imem_instr, if_id_pc<=pc, if_id_link<=pc+8. Otherwise hold.
- Pending redirect:
  - id_ta_instr with npc_le==0 sets pending=1 and pending_ta<=id_target_addr.
  - The next edge with npc_le==1 consumes it and clears pending.
  - A new id_ta_instr while pending wins and overwrites pending_ta.
- misalign_err: set on any edge where a redirect is consumed or captured with target[1:0]!=0. Cleared only by reset. The PC still loads the unmodified target.
- Arithmetic: 32-bit unsigned adds; wrap at 2^32 silently.
- imem_addr is combinational from pc: no extra latency, and the instruction appears in IF/ID one edge after pc is valid.
- Counters:
  - fetch_count increments when if_id_le loads in RUN.
  - stall_count increments when pc_le==0 in RUN.
  - Both saturate at all-ones.
- Reset mid-operation: all state returns to reset values immediately (async). Any pending redirect is discarded.
- pc_le==1 with npc_le==0 is legal: pc<=npc repeats the same nPC.

Decomposition:
- Shared package/header: NOP encoding (32'h0), PC increment constant (4), link offset (8), BOOT/RUN state encodings.
- One natural sub-module: sat_counter (CNT_W-bit saturating counter with enable), instantiated twice.

Test Plan:
- Reset then free-run, all LEs=1, imem returns addr-tagged words → pc goes 0,4,8,12; IF/ID holds NOP on the first edge after release, then instr@0 with if_id_pc=0 and if_id_link=8; fetch_count=3 after 4 edges.
- Stall: pc_le=npc_le=if_id_le=0 for 3 cycles at pc=8 → pc/npc/IF/ID frozen; stall_count=3; normal resume at pc=8.
- Taken branch: id_ta_instr=1, target=0x40, asserted when pc=8, npc=12 → next pc=12 (delay slot), npc=0x40; the following pc=0x40.
- Branch during stall: id_ta_instr=1, target=0x80, npc_le=0 → pending held; two edges later npc_le=1 → npc=0x80, pending cleared.
- Misaligned target 0x42 → misalign_err=1 on the redirect edge and stays 1 until reset; npc=0x42.
- Async reset asserted mid-cycle with pending set → all outputs return to reset values before the next edge; pending is not applied after release.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end:
// NOP encoding, PC arithmetic constants and fetch FSM states.
package if_fetch_unit_pkg;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [31:0] LINK_OFS = 32'd8;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones.
// Ports: i_clk, i_rst_n (async low), i_en, o_count[W-1:0].
module if_fetch_unit_sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_full;

    assign w_full  = &r_count;
    assign o_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_en && !w_full) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: PC/nPC pair with delayed-branch redirect, IF/ID register,
// fetch/stall counters.
// Ports: clk, reset (async low); pc_le/npc_le/if_id_le hazard enables;
// id_ta_instr/id_target_addr redirect from ID; imem_instr/imem_addr;
// pc_out, npc_out, if_id_{instr,pc,link}, misalign_err,
// fetch_count, stall_count.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] RESET_NPC = 32'd4,
    parameter int          IMEM_AW   = 9,
    parameter int          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_le,
    input  logic               npc_le,
    input  logic               if_id_le,
    input  logic               id_ta_instr,
    input  logic [31:0]        id_target_addr,
    input  logic [31:0]        imem_instr,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        pc_out,
    output logic [31:0]        npc_out,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_link,
    output logic               misalign_err,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   stall_count
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic         w_run;

    logic [31:0]  r_pc;
    logic [31:0]  r_npc;
    logic         r_pending;
    logic [31:0]  r_pending_ta;
    logic         r_misalign;
    logic [31:0]  r_if_instr;
    logic [31:0]  r_if_pc;
    logic [31:0]  r_if_link;

    logic         w_redirect;
    logic [31:0]  w_target;
    logic         w_misalign;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        unique case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN:  w_run       = 1'b1;
        endcase
    end

    // A fresh redirect from ID takes priority over a held one.
    assign w_redirect = id_ta_instr | r_pending;
    assign w_target   = id_ta_instr ? id_target_addr : r_pending_ta;

    // Flag whenever a target is either consumed or captured into pending.
    assign w_misalign = w_run & w_redirect
                      & (npc_le | id_ta_instr)
                      & (|w_target[1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_PC;
            r_npc        <= RESET_NPC;
            r_pending    <= 1'b0;
            r_pending_ta <= '0;
        end else if (w_run) begin
            if (pc_le) begin
                r_pc <= r_npc;
            end
            if (npc_le) begin
                r_npc     <= w_redirect ? w_target : r_npc + PC_INC;
                r_pending <= 1'b0;
            end else if (id_ta_instr) begin
                r_pending    <= 1'b1;
                r_pending_ta <= id_target_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misalign <= 1'b0;
        end else if (w_misalign) begin
            r_misalign <= 1'b1;
        end
    end

    // The boot edge forces a bubble so ID never sees a stale fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_instr <= NOP;
            r_if_pc    <= '0;
            r_if_link  <= '0;
        end else if (!w_run) begin
            r_if_instr <= NOP;
            r_if_pc    <= '0;
            r_if_link  <= '0;
        end else if (if_id_le) begin
            r_if_instr <= imem_instr;
            r_if_pc    <= r_pc;
            r_if_link  <= r_pc + LINK_OFS;
        end
    end

    if_fetch_unit_sat_counter #(
        .W (CNT_W)
    ) u_fetch_cnt (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_en    (w_run & if_id_le),
        .o_count (fetch_count)
    );

    if_fetch_unit_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_en    (w_run & ~pc_le),
        .o_count (stall_count)
    );

    assign imem_addr    = r_pc[IMEM_AW-1:0];
    assign pc_out       = r_pc;
    assign npc_out      = r_npc;
    assign if_id_instr  = r_if_instr;
    assign if_id_pc     = r_if_pc;
    assign if_id_link   = r_if_link;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: the driver queues the
// expected post-edge state, a negedge monitor pops and compares.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_le, npc_le, if_id_le, id_ta_instr;
    logic [31:0] id_target_addr;
    logic [31:0] imem_instr;
    logic [8:0]  imem_addr;
    logic [31:0] pc_out, npc_out;
    logic [31:0] if_id_instr, if_id_pc, if_id_link;
    logic        misalign_err;
    logic [2:0]  fetch_count, stall_count;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ins;
        logic [31:0] ipc;
        logic [31:0] lnk;
        logic        mis;
        logic [2:0]  fc;
        logic [2:0]  sc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign imem_instr = 32'hC0DE_0000 | {23'd0, imem_addr};

    if_fetch_unit #(
        .RESET_PC  (32'd0),
        .RESET_NPC (32'd4),
        .IMEM_AW   (9),
        .CNT_W     (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_le          (pc_le),
        .npc_le         (npc_le),
        .if_id_le       (if_id_le),
        .id_ta_instr    (id_ta_instr),
        .id_target_addr (id_target_addr),
        .imem_instr     (imem_instr),
        .imem_addr      (imem_addr),
        .pc_out         (pc_out),
        .npc_out        (npc_out),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_link     (if_id_link),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
    );

    function automatic logic [31:0] tg(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    task automatic chk(input string nm, input int c,
                       input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, act, ex);
        end
    endtask

    task automatic push(input int c,
                        input logic [31:0] p, input logic [31:0] np,
                        input logic [31:0] ins, input logic [31:0] ip,
                        input logic [31:0] ln, input logic mi,
                        input logic [2:0] fc, input logic [2:0] sc);
        exp_t e;
        e.cyc = c; e.pc = p; e.npc = np; e.ins = ins;
        e.ipc = ip; e.lnk = ln; e.mis = mi; e.fc = fc; e.sc = sc;
        q.push_back(e);
    endtask

    // Drive inputs for the coming edge and queue the state after it.
    task automatic step(input logic pl, input logic nl, input logic il,
                        input logic ta, input logic [31:0] tgt,
                        input logic [31:0] p, input logic [31:0] np,
                        input logic [31:0] ins, input logic [31:0] ip,
                        input logic [31:0] ln, input logic mi,
                        input logic [2:0] fc, input logic [2:0] sc);
        pc_le = pl; npc_le = nl; if_id_le = il;
        id_ta_instr = ta; id_target_addr = tgt;
        push(cyc + 1, p, np, ins, ip, ln, mi, fc, sc);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk("missed_sample", e.cyc, 32'(cyc), 32'(e.cyc));
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("pc",       cyc, pc_out,                e.pc);
            chk("imem_addr", cyc, {23'd0, imem_addr},   {23'd0, e.pc[8:0]});
            chk("npc",      cyc, npc_out,               e.npc);
            chk("ifid_ins", cyc, if_id_instr,           e.ins);
            chk("ifid_pc",  cyc, if_id_pc,              e.ipc);
            chk("ifid_lnk", cyc, if_id_link,            e.lnk);
            chk("misalign", cyc, {31'd0, misalign_err}, {31'd0, e.mis});
            chk("fetch_cnt", cyc, {29'd0, fetch_count}, {29'd0, e.fc});
            chk("stall_cnt", cyc, {29'd0, stall_count}, {29'd0, e.sc});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        pc_le = 1'b1; npc_le = 1'b1; if_id_le = 1'b1;
        id_ta_instr = 1'b0; id_target_addr = 32'd0;
        push(1, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 3'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // boot edge, then free run
        step(1,1,1,0,0,   0,    4,    0,          0,    0,    0,0,0);
        step(1,1,1,0,0,   4,    8,    tg(0),      0,    8,    0,1,0);
        step(1,1,1,0,0,   8,    12,   tg(4),      4,    12,   0,2,0);
        // stall three edges at pc=8
        step(0,0,0,0,0,   8,    12,   tg(4),      4,    12,   0,2,1);
        step(0,0,0,0,0,   8,    12,   tg(4),      4,    12,   0,2,2);
        step(0,0,0,0,0,   8,    12,   tg(4),      4,    12,   0,2,3);
        step(1,1,1,0,0,   12,   16,   tg(8),      8,    16,   0,3,3);
        // taken branch: delay slot then target
        step(1,1,1,1,'h40, 16,  'h40, tg(12),     12,   20,   0,4,3);
        step(1,1,1,0,0,   'h40, 'h44, tg(16),     16,   24,   0,5,3);
        // branch captured during stall, consumed later
        step(0,0,0,1,'h80, 'h40,'h44, tg(16),     16,   24,   0,5,4);
        step(0,0,0,0,0,   'h40, 'h44, tg(16),     16,   24,   0,5,5);
        step(1,1,1,0,0,   'h44, 'h80, tg('h40),   'h40, 'h48, 0,6,5);
        step(1,1,1,0,0,   'h80, 'h84, tg('h44),   'h44, 'h4C, 0,7,5);
        // misaligned target; fetch counter saturated at 7
        step(1,1,1,1,'h42, 'h84,'h42, tg('h80),   'h80, 'h88, 1,7,5);
        step(1,1,1,0,0,   'h42, 'h46, tg('h84),   'h84, 'h8C, 1,7,5);
        // pc_le without npc_le repeats nPC
        step(1,0,1,0,0,   'h46, 'h46, tg('h42),   'h42, 'h4A, 1,7,5);
        // capture a pending redirect to 0x100
        step(1,0,1,1,'h100,'h46,'h46, tg('h46),   'h46, 'h4E, 1,7,5);

        // async reset pulse between edges discards pending
        pc_le = 1'b1; npc_le = 1'b1; if_id_le = 1'b1;
        id_ta_instr = 1'b0; id_target_addr = 32'd0;
        push(cyc + 1, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 3'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        step(1,1,1,0,0,   4,    8,    tg(0),      0,    8,    0,1,0);
        step(1,1,1,0,0,   8,    12,   tg(4),      4,    12,   0,2,0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
